// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared types for the H-bridge gate driver.
package hbridge_pkg;

  typedef enum logic [1:0] {LEG_OFF, LEG_HIGH, LEG_LOW} leg_cmd_t;
  typedef enum logic [1:0] {L_OFF, L_HIGH, L_LOW, L_DEAD} leg_state_t;
  typedef enum logic {RUN, REVERSE} top_state_t;

  // Steady leg state that a command asks for once any dead-time has elapsed.
  function automatic leg_state_t cmd_state(input leg_cmd_t c);
    case (c)
      LEG_HIGH: cmd_state = L_HIGH;
      LEG_LOW:  cmd_state = L_LOW;
      default:  cmd_state = L_OFF;
    endcase
  endfunction

endpackage

// File: rtl/hbridge_if.sv
// hbridge_if: PWM/direction inputs and gate/status outputs of the H-bridge driver.
interface hbridge_if;
  logic pdcm;
  logic dir;
  logic hs_a;
  logic ls_a;
  logic hs_b;
  logic ls_b;
  logic reversing;

  modport master (output pdcm, dir, input hs_a, ls_a, hs_b, ls_b, reversing);
  modport slave  (input pdcm, dir, output hs_a, ls_a, hs_b, ls_b, reversing);
endinterface

// File: rtl/hbridge_leg.sv
// hbridge_leg: one half-bridge with dead-time inserted on every switch-on.
// Gates decode straight from the state register, so an async reset drops them at once.
module hbridge_leg
  import hbridge_pkg::*;
#(
  parameter int DEAD_CYCLES = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  leg_cmd_t cmd,
  output logic     hs,
  output logic     ls
);

  localparam int CW = $clog2(DEAD_CYCLES + 1);
  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES - 1);

  leg_state_t    state, state_nx, target;
  logic [CW-1:0] cnt, cnt_nx;

  assign target = cmd_state(cmd);

  // State and dead counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= L_OFF;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Switching off is immediate; switching on always passes through L_DEAD,
  // whose count is never restarted by a command change.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == L_DEAD) begin
      if (cnt == '0) state_nx = target;
      else           cnt_nx   = cnt - CW'(1);
    end else if (target != state) begin
      if (target == L_OFF) begin
        state_nx = L_OFF;
      end else begin
        state_nx = L_DEAD;
        cnt_nx   = DEAD_LOAD;
      end
    end
  end

  assign hs = (state == L_HIGH);
  assign ls = (state == L_LOW);

endmodule

// File: rtl/hbridge_driver.sv
// hbridge_driver: full H-bridge gate driver fed by the dc_motor PWM stage.
// Optional macro HBRIDGE_SYNC_RECT_EN: drive the PWM leg low side during the
// pdcm low phase (synchronous rectification) instead of leaving it off.
module hbridge_driver
  import hbridge_pkg::*;
#(
  parameter int DEAD_CYCLES    = 4,
  parameter int REVERSE_CYCLES = 16
) (
  input logic       clk,
  input logic       rst,
  hbridge_if.slave  bus
);

  localparam int RW = $clog2(REVERSE_CYCLES + 1);
  localparam logic [RW-1:0] REV_LOAD = RW'(REVERSE_CYCLES - 1);

  logic          pdcm_q, dir_q, dir_lat, dir_lat_nx;
  top_state_t    state, state_nx;
  logic [RW-1:0] rev_cnt, rev_cnt_nx;
  leg_cmd_t      pwm_cmd, cmd_a, cmd_b;
  logic          hs_a, ls_a, hs_b, ls_b;

  // Single input register stage; the motor stage is already on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdcm_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      pdcm_q <= bus.pdcm;
      dir_q  <= bus.dir;
    end
  end

  // Top state, reversal counter and latched direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      rev_cnt <= '0;
      dir_lat <= 1'b0;
    end else begin
      state   <= state_nx;
      rev_cnt <= rev_cnt_nx;
      dir_lat <= dir_lat_nx;
    end
  end

  // Reversal coast runs its full length; direction is resampled only at its end.
  always_comb begin
    state_nx   = state;
    rev_cnt_nx = rev_cnt;
    dir_lat_nx = dir_lat;
    case (state)
      RUN: if (dir_q != dir_lat) begin
        state_nx   = REVERSE;
        rev_cnt_nx = REV_LOAD;
      end
      REVERSE: if (rev_cnt == '0) begin
        state_nx   = RUN;
        dir_lat_nx = dir_q;
      end else begin
        rev_cnt_nx = rev_cnt - RW'(1);
      end
      default: state_nx = RUN;
    endcase
  end

`ifdef HBRIDGE_SYNC_RECT_EN
  assign pwm_cmd = pdcm_q ? LEG_HIGH : LEG_LOW;
`else
  assign pwm_cmd = pdcm_q ? LEG_HIGH : LEG_OFF;
`endif

  // Leg commands. The dir_q mismatch term turns both legs off on the same clock
  // the reversal is detected, keeping switch-off at two clocks from the dir edge.
  always_comb begin
    cmd_a = LEG_OFF;
    cmd_b = LEG_OFF;
    if (state == RUN && dir_q == dir_lat) begin
      if (!dir_lat) begin
        cmd_a = pwm_cmd;
        cmd_b = LEG_LOW;
      end else begin
        cmd_a = LEG_LOW;
        cmd_b = pwm_cmd;
      end
    end
  end

  hbridge_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
    .clk (clk), .rst (rst), .cmd (cmd_a), .hs (hs_a), .ls (ls_a)
  );

  hbridge_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
    .clk (clk), .rst (rst), .cmd (cmd_b), .hs (hs_b), .ls (ls_b)
  );

  assign bus.hs_a      = hs_a;
  assign bus.ls_a      = ls_a;
  assign bus.hs_b      = hs_b;
  assign bus.ls_b      = ls_b;
  assign bus.reversing = (state == REVERSE);

endmodule

// File: tb/tb_hbridge_driver.sv
// tb_hbridge_driver: directed plus randomized stimulus; a per-clock reference
// model pushes expected {reversing, hs_a, ls_a, hs_b, ls_b} into a queue and a
// negedge monitor pops and compares.
module tb_hbridge_driver;

  localparam int D = 4;
  localparam int R = 16;
`ifdef HBRIDGE_SYNC_RECT_EN
  localparam int SR = 1;
`else
  localparam int SR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hbridge_if bus();

  hbridge_driver #(.DEAD_CYCLES(D), .REVERSE_CYCLES(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [4:0] expq[$];

  // Reference model. cond: 0 = both off, 1 = high side on, 2 = low side on.
  // wait_left: clocks of dead-time still to run before the leg may conduct.
  int m_pq, m_dq, m_lat, m_coast;
  int m_cond[2];
  int m_wait[2];

  task automatic model_reset();
    m_pq = 0; m_dq = 0; m_lat = 0; m_coast = 0;
    for (int i = 0; i < 2; i++) begin
      m_cond[i] = 0;
      m_wait[i] = 0;
    end
  endtask

  task automatic model_leg(input int i, input int want);
    if (m_wait[i] > 0) begin
      if (m_wait[i] == 1) m_cond[i] = want;
      m_wait[i] = m_wait[i] - 1;
    end else if (want != m_cond[i]) begin
      m_cond[i] = 0;
      if (want != 0) m_wait[i] = D;
    end
  endtask

  task automatic model_step(input int p, input int d);
    int want_a, want_b, pwm;
    want_a = 0;
    want_b = 0;
    if (m_coast == 0 && m_dq == m_lat) begin
      pwm = (m_pq != 0) ? 1 : ((SR != 0) ? 2 : 0);
      if (m_lat == 0) begin want_a = pwm; want_b = 2; end
      else            begin want_a = 2;   want_b = pwm; end
    end
    model_leg(0, want_a);
    model_leg(1, want_b);
    if (m_coast > 0) begin
      m_coast = m_coast - 1;
      if (m_coast == 0) m_lat = m_dq;
    end else if (m_dq != m_lat) begin
      m_coast = R;
    end
    m_pq = p;
    m_dq = d;
  endtask

  function automatic logic [4:0] model_out();
    return {m_coast > 0, m_cond[0] == 1, m_cond[0] == 2, m_cond[1] == 1, m_cond[1] == 2};
  endfunction

  // One clock: advance the model with the inputs present at the edge.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_step(int'(bus.pdcm), int'(bus.dir));
    expq.push_back(model_out());
    #1;
  endtask

  // Assert reset between edges and check that everything drops without a clock.
  task automatic async_reset_check(input string name);
    logic [4:0] got;
    #1;
    rst = 1'b1;
    #1;
    got = {bus.reversing, bus.hs_a, bus.ls_a, bus.hs_b, bus.ls_b};
    tests++;
    if (got !== 5'b0) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b exp=00000", name, cyc, got);
    end
    expq.delete();
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  // Monitor: every clock the DUT presents gates, compare with the oldest expectation.
  always @(negedge clk) begin
    logic [4:0] e, got;
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      got = {bus.reversing, bus.hs_a, bus.ls_a, bus.hs_b, bus.ls_b};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL gates cyc=%0d got={rev,hsa,lsa,hsb,lsb}=%b exp=%b", cyc, got, e);
      end
    end
  end

  initial begin
    int n;
    model_reset();
    bus.pdcm = 1'b1;
    bus.dir  = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;

    // Start-up with pdcm held high, forward.
    repeat (12) cycle();

    // 10/10 PWM, forward.
    for (int k = 0; k < 60; k++) begin
      bus.pdcm = ((k % 20) < 10);
      cycle();
    end

    // Short 2-clock pulse from steady low.
    bus.pdcm = 1'b0;
    repeat (14) cycle();
    bus.pdcm = 1'b1;
    repeat (2) cycle();
    bus.pdcm = 1'b0;
    repeat (14) cycle();

    // Reversal with PWM running.
    bus.dir = 1'b1;
    for (int k = 0; k < 50; k++) begin
      bus.pdcm = ((k % 20) < 10);
      cycle();
    end

    // Direction glitch back to reverse-then-forward.
    bus.pdcm = 1'b1;
    bus.dir  = 1'b0;
    repeat (30) cycle();
    bus.dir = 1'b1;
    repeat (3) cycle();
    bus.dir = 1'b0;
    repeat (30) cycle();

    // Reset while leg A is in dead-time.
    bus.pdcm = 1'b0;
    repeat (10) cycle();
    bus.pdcm = 1'b1;
    repeat (3) cycle();
    async_reset_check("rst_dead");
    repeat (12) cycle();

    // Reset in the middle of a reversal coast.
    bus.dir = 1'b1;
    repeat (8) cycle();
    async_reset_check("rst_reverse");
    repeat (8) cycle();

    // Randomized PWM run lengths with occasional direction changes and glitches.
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 9) == 0) bus.dir = ~bus.dir;
      bus.pdcm = ~bus.pdcm;
      n = $urandom_range(1, 12);
      repeat (n) cycle();
    end

    // Drain the scoreboard.
    @(negedge clk);
    #1;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending exp=0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hbridge_driver.md
# hbridge_driver

- Sits directly downstream of the `dc_motor` PWM generator and consumes its `pdcm` (PWM) and `dir` outputs.
- Produces the four gate signals of a full H-bridge: high/low side of leg A and high/low side of leg B.
- Guarantees that the two switches of one leg are never on together, by inserting dead-time on every switch-on.
- On a direction change it forces a timed coast (all switches off) before driving the opposite direction.

## Interface
- `DEAD_CYCLES`, default 4: clocks with both switches of a leg off before either switch turns on; must be ≥ 1.
- `REVERSE_CYCLES`, default 16: clocks of full coast on a direction change; must be ≥ 1.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `pdcm`  input  1  PWM from the motor stage, synchronous to `clk`.
- `dir`  input  1  direction from the motor stage: 0 = forward, 1 = reverse.
- `hs_a`, `ls_a`  output  1 each  leg A high-side / low-side gate.
- `hs_b`, `ls_b`  output  1 each  leg B high-side / low-side gate.
- `reversing`  output  1  high while the reversal coast is in progress.

## Operation
- `pdcm` and `dir` are registered once into `pdcm_q` and `dir_q`. There is no further synchronisation.
- Top FSM has two states: RUN and REVERSE.
  - RUN: uses the latched direction `dir_lat`.
  - RUN → REVERSE when `dir_q != dir_lat`. Counter loads `REVERSE_CYCLES-1`.
  - REVERSE: both legs are commanded OFF. Counter decrements each clock.
  - REVERSE → RUN at count 0. At that point `dir_lat <= dir_q`. If `dir` has toggled back, the block resumes the old direction; the count is never restarted or shortened.
- Leg commands in RUN, forward (`dir_lat=0`):
  - Leg A = HIGH when `pdcm_q=1`, otherwise LOW (see Configuration).
  - Leg B = LOW.
- Leg commands in RUN, reverse: same mapping with leg A and leg B swapped.
- Each leg is a Moore FSM with states L_OFF, L_HIGH, L_LOW, L_DEAD.
  - L_HIGH drives `hs=1`. L_LOW drives `ls=1`. L_OFF and L_DEAD drive both 0.
  - From L_OFF, L_HIGH or L_LOW: a command differing from the current state gives one of two transitions:
    - command OFF → L_OFF.
    - command HIGH or LOW → L_DEAD, with the dead counter loaded to `DEAD_CYCLES-1`.
  - In L_DEAD: the counter decrements. At 0 the leg moves to the state of the current command (L_OFF, L_HIGH or L_LOW).
  - Command changes during L_DEAD neither extend nor restart the count.
- Counter widths are `$clog2(N+1)`. Counters saturate at 0 and never wrap.
- `hs && ls` for either leg is never true in any state.

## Timing
- Reset values: all four gates = 0, `reversing=0`, `dir_lat=0`, top FSM = RUN, both legs = L_OFF, all counters = 0.
- Assertion of `rst` clears all outputs immediately, independent of `clk`. This includes assertion mid-reversal or mid-dead-time.
- Latency from a `pdcm`/`dir` edge to a leg state change: 2 clocks (input register plus leg state register).
- Switch-on latency: a switch turns on exactly `DEAD_CYCLES` clocks after its leg enters L_DEAD.
- Switch-off latency: a switch turns off 2 clocks after the causing input edge.
- `reversing` is registered. It is high for exactly `REVERSE_CYCLES` clocks, starting 2 clocks after the `dir` edge.
- PWM pulses shorter than `DEAD_CYCLES` may be absorbed entirely; this is required behaviour.

## Configuration
- Macro: `HBRIDGE_SYNC_RECT_EN`.
- Defined: synchronous rectification. The PWM leg is commanded LOW during the `pdcm` low phase, so the low side conducts with dead-time on both sides of each PWM edge.
- Undefined: the PWM leg is commanded OFF during the `pdcm` low phase and current freewheels through the body diodes. The PWM leg's `ls` then stays 0 throughout RUN. The static leg is unaffected.

## Structure
- Shared package `hbridge_pkg` holds:
  - `leg_cmd_t` enum: LEG_OFF, LEG_HIGH, LEG_LOW.
  - `leg_state_t` enum: L_OFF, L_HIGH, L_LOW, L_DEAD.
  - `top_state_t` enum: RUN, REVERSE.
- One sub-module, `hbridge_leg`: the per-leg dead-time FSM (parameter `DEAD_CYCLES`; ports `clk`, `rst`, `cmd`, `hs`, `ls`). It is instantiated twice.

## Test plan
All scenarios use `DEAD_CYCLES=4` and `REVERSE_CYCLES=16`.
- **Start-up.** Release `rst` with `dir=0`, `pdcm=1` held → `ls_b=1` and `hs_a=1` by clock 6; `hs_b=ls_a=0` throughout.
- **PWM with sync rectification** (macro defined). `pdcm` 10 clocks high / 10 low, `dir=0`.
  - `hs_a` high 6 clocks, then 4 clocks both off, then `ls_a` high 6 clocks, repeating.
  - `hs_a&ls_a` is never 1.
- **Short pulse.** A 2-clock `pdcm` pulse from steady low (macro defined) → `ls_a` drops for exactly 4 clocks then returns; `hs_a` never rises.
- **Reversal.** Steady forward, then `dir` 0→1.
  - All gates 0 within 2 clocks; `reversing=1` for exactly 16 clocks.
  - Then `ls_a=1` and `hs_b` follows `pdcm`, each after 4 dead clocks.
- **Direction glitch.** `dir` 0→1→0 with 3 clocks high → full 16-clock coast, then resume forward (`ls_b=1`); no second reversal.
- **Reset mid-operation.**
  - Assert `rst` during dead-time → all gates 0 with no `clk` edge.
  - With macro undefined, `pdcm` low → `ls_a` stays 0.
